// File: rtl/tach_pkg.sv
// Shared defaults and elaboration-time RPM scale helpers for the tachometer interface.
// No logic; latency and backpressure not applicable.
package tach_pkg;

  localparam int unsigned DEF_CLK_EN_HZ      = 10000;
  localparam int unsigned DEF_WINDOW_TICKS   = 500;
  localparam int unsigned DEF_PULSES_PER_REV = 360;
  localparam int unsigned DEF_COUNT_WIDTH    = 16;
  localparam int unsigned DEF_RPM_WIDTH      = 10;

  function automatic longint unsigned gcd_u(longint unsigned a, longint unsigned b);
    longint unsigned x;
    longint unsigned y;
    longint unsigned t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // rpm = count * 60 * hz / (ticks * ppr); reduced so the divider stays small.
  function automatic longint unsigned rpm_scale_num(int unsigned hz, int unsigned ticks,
                                                   int unsigned ppr);
    longint unsigned n;
    longint unsigned d;
    n = 64'(hz) * 64'd60;
    d = 64'(ticks) * 64'(ppr);
    return n / gcd_u(n, d);
  endfunction

  function automatic longint unsigned rpm_scale_den(int unsigned hz, int unsigned ticks,
                                                   int unsigned ppr);
    longint unsigned n;
    longint unsigned d;
    n = 64'(hz) * 64'd60;
    d = 64'(ticks) * 64'(ppr);
    return d / gcd_u(n, d);
  endfunction

endpackage

// File: rtl/tach_rpm_interface_sync_edge_detect.sv
// Two-flop synchronizer plus rising-edge pulse for an asynchronous input.
// Latency: rise_out is high the cycle after the second sync flop sees the edge; no backpressure.
module sync_edge_detect (
  input  logic clk_in,
  input  logic reset_in,
  input  logic async_in,
  output logic rise_out
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise_out = sync2_q & ~prev_q;

endmodule

// File: rtl/tach_rpm_interface.sv
// Gated tachometer edge counter converted to saturating RPM once per window.
// Latency: output updates one cycle after each window end; free-running, no backpressure.
module tach_rpm_interface #(
  parameter int unsigned CLK_EN_HZ      = tach_pkg::DEF_CLK_EN_HZ,
  parameter int unsigned WINDOW_TICKS   = tach_pkg::DEF_WINDOW_TICKS,
  parameter int unsigned PULSES_PER_REV = tach_pkg::DEF_PULSES_PER_REV,
  parameter int unsigned COUNT_WIDTH    = tach_pkg::DEF_COUNT_WIDTH,
  parameter int unsigned RPM_WIDTH      = tach_pkg::DEF_RPM_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 clk_en,
  input  logic                 tachometer_pulse_in,
  output logic [RPM_WIDTH-1:0] actual_rpm_out
);

  import tach_pkg::*;

  localparam int unsigned TICK_W = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam int unsigned PROD_W = COUNT_WIDTH + 24;
  localparam longint unsigned SCALE_NUM = rpm_scale_num(CLK_EN_HZ, WINDOW_TICKS, PULSES_PER_REV);
  localparam longint unsigned SCALE_DEN = rpm_scale_den(CLK_EN_HZ, WINDOW_TICKS, PULSES_PER_REV);

  localparam logic [TICK_W-1:0]      TICK_LAST = TICK_W'(WINDOW_TICKS - 1);
  localparam logic [PROD_W-1:0]      NUM_W     = PROD_W'(SCALE_NUM);
  localparam logic [PROD_W-1:0]      DEN_W     = PROD_W'(SCALE_DEN);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [RPM_WIDTH-1:0]   RPM_MAX   = '1;

  logic                   rise;
  logic                   win_end;
  logic [TICK_W-1:0]      tick_q,         tick_d;
  logic [COUNT_WIDTH-1:0] pulse_count_q,  pulse_count_d;
  logic [COUNT_WIDTH-1:0] window_count_q, window_count_d;
  logic                   upd_q,          upd_d;
  logic [RPM_WIDTH-1:0]   rpm_q,          rpm_d;
  logic [PROD_W-1:0]      prod;
  logic [PROD_W-1:0]      quot;

  sync_edge_detect u_sync_edge (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .async_in (tachometer_pulse_in),
    .rise_out (rise)
  );

  assign win_end = clk_en && (tick_q == TICK_LAST);

  always_comb begin
    tick_d         = tick_q;
    pulse_count_d  = pulse_count_q;
    window_count_d = window_count_q;
    upd_d          = win_end;

    if (clk_en) begin
      tick_d = win_end ? '0 : tick_q + 1'b1;
    end

    // A same-cycle edge is folded into the closing window, never the new one.
    if (win_end) begin
      pulse_count_d = '0;
      if (rise && (pulse_count_q != CNT_MAX)) begin
        window_count_d = pulse_count_q + 1'b1;
      end else begin
        window_count_d = pulse_count_q;
      end
    end else if (rise && (pulse_count_q != CNT_MAX)) begin
      pulse_count_d = pulse_count_q + 1'b1;
    end
  end

  always_comb begin
    prod  = PROD_W'(window_count_q) * NUM_W;
    quot  = prod / DEN_W;
    rpm_d = rpm_q;
    if (upd_q) begin
      rpm_d = (quot > PROD_W'(RPM_MAX)) ? RPM_MAX : quot[RPM_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      tick_q         <= '0;
      pulse_count_q  <= '0;
      window_count_q <= '0;
      upd_q          <= 1'b0;
      rpm_q          <= '0;
    end else begin
      tick_q         <= tick_d;
      pulse_count_q  <= pulse_count_d;
      window_count_q <= window_count_d;
      upd_q          <= upd_d;
      rpm_q          <= rpm_d;
    end
  end

  assign actual_rpm_out = rpm_q;

endmodule

// File: tb/tb_tach_rpm_interface.sv
// Bench for tach_rpm_interface: directed and random pulse trains scored against a window/RPM model.
// Inputs are driven 1 ns after each rising clock edge; outputs are sampled at that same point.
module tb_tach_rpm_interface;

  localparam int CLK_EN_HZ = 10000;
  localparam int W         = 500;
  localparam int PPR       = 360;
  localparam int RPM_MAX   = 1023;
  localparam int CNT_MAX   = 65535;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       clk_en;
  logic       tachometer_pulse_in;
  logic [9:0] actual_rpm_out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int s;
    int h;
  } req_t;

  req_t reqs[$];

  tach_rpm_interface dut (
    .clk_in              (clk_in),
    .reset_in            (reset_in),
    .clk_en              (clk_en),
    .tachometer_pulse_in (tachometer_pulse_in),
    .actual_rpm_out      (actual_rpm_out)
  );

  always #4 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_rpm(input int n);
    longint c;
    longint r;
    c = (n > CNT_MAX) ? CNT_MAX : n;
    r = (c * 60 * CLK_EN_HZ) / (W * PPR);
    return (r > RPM_MAX) ? RPM_MAX : int'(r);
  endfunction

  task automatic do_reset();
    clk_en              = 1'b0;
    tachometer_pulse_in = 1'b0;
    @(negedge clk_in);
    reset_in = 1'b1;
    #1;
    check_val("reset_out", actual_rpm_out, 0);
    @(negedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  // Edge e=1 is the first rising edge after reset release; clk_en is high on every edge with e%p==0.
  // A pulse high on edges [s, s+h) is counted at edge s+2 and belongs to the window holding the
  // next tick at or after that edge, i.e. window ((s+1)/p)/W.
  task automatic run_seg(input int p, input int nwin, input int abort_e, input string name);
    int cnt[16];
    int wp;
    int last_e;
    int ri;
    int prev;
    int k;
    int w;
    wp = W * p;
    foreach (cnt[i]) cnt[i] = 0;
    foreach (reqs[i]) begin
      w = ((reqs[i].s + 1) / p) / W;
      if (w < 16) cnt[w]++;
    end
    last_e = (abort_e > 0) ? abort_e : nwin * wp + 2;
    ri     = 0;
    prev   = 0;
    for (int e = 1; e <= last_e; e++) begin
      clk_en = ((e % p) == 0);
      while (ri < reqs.size() && (reqs[ri].s + reqs[ri].h) <= e) ri++;
      tachometer_pulse_in = (ri < reqs.size()) && (e >= reqs[ri].s);
      @(posedge clk_in);
      #1;
      if ((e % wp) == 0 && (e / wp) <= nwin) begin
        check_val($sformatf("%s_hold_w%0d", name, e / wp - 1), actual_rpm_out, prev);
      end
      if (e > 1 && ((e - 1) % wp) == 0 && ((e - 1) / wp) <= nwin) begin
        k    = (e - 1) / wp - 1;
        prev = exp_rpm(cnt[k]);
        check_val($sformatf("%s_rpm_w%0d", name, k), actual_rpm_out, prev);
      end
    end
    if (abort_e > 0) begin
      reset_in = 1'b1;
      #1;
      check_val($sformatf("%s_abort_out", name), actual_rpm_out, 0);
    end
    clk_en              = 1'b0;
    tachometer_pulse_in = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    int p;
    int maxgap;
    int s;
    int h;
    reset_in            = 1'b1;
    clk_en              = 1'b0;
    tachometer_pulse_in = 1'b0;
    #20;
    check_val("por_out", actual_rpm_out, 0);

    // Idle: no pulses, output must stay 0 through two window ends.
    do_reset();
    reqs.delete();
    run_seg(4, 2, 0, "idle");

    // Nominal: 100 pulses of 1 tick high / 1 tick low from tick 2, then an empty window.
    do_reset();
    reqs.delete();
    for (int i = 0; i < 100; i++) reqs.push_back('{2 * 4 + i * 8 + 1, 4});
    run_seg(4, 2, 0, "nominal");

    // Low speed, a pulse held across a boundary, and an edge landing on the window-end cycle.
    do_reset();
    reqs.delete();
    reqs.push_back('{100, 5});
    reqs.push_back('{200, 5});
    reqs.push_back('{300, 5});
    reqs.push_back('{1600, 3});
    reqs.push_back('{3100, 2});
    reqs.push_back('{3 * 1500 - 40, 100});
    reqs.push_back('{4 * 1500 - 2, 4});
    run_seg(3, 5, 0, "boundary");

    // Saturation: 400 pulses in one window.
    do_reset();
    reqs.delete();
    for (int i = 0; i < 400; i++) reqs.push_back('{10 + 2 * i, 1});
    run_seg(2, 2, 0, "sat");

    // Reset mid-window after one completed window, then a fresh window.
    do_reset();
    reqs.delete();
    for (int i = 0; i < 30; i++) reqs.push_back('{20 + 10 * i, 4});
    for (int i = 0; i < 50; i++) reqs.push_back('{2020 + 10 * i, 3});
    run_seg(4, 2, W * 4 + 250 * 4, "midrst");
    do_reset();
    reqs.delete();
    for (int i = 0; i < 30; i++) reqs.push_back('{20 + 10 * i, 4});
    run_seg(4, 1, 0, "after_rst");

    // Random densities and strobe periods, including continuous clk_en.
    for (int r = 0; r < 6; r++) begin
      p      = $urandom_range(1, 4);
      maxgap = $urandom_range(1, 12);
      do_reset();
      reqs.delete();
      s = $urandom_range(2, 20);
      while (s < 2 * W * p - 10) begin
        h = $urandom_range(1, maxgap);
        reqs.push_back('{s, h});
        s = s + h + $urandom_range(1, maxgap);
      end
      run_seg(p, 2, 0, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
